// File: rtl/conv3x3_frame_sequencer.sv
// 3x3 signed convolution frame sequencer: walks a WIDTHxHEIGHT image in raster order,
// reads nine taps per interior pixel from sync RAM, and streams |acc| clamped to 2^BITW-1.
module conv3x3_frame_sequencer #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned HEIGHT = 16,
    parameter int unsigned BITW   = 8,
    parameter int unsigned ACCW   = 20,
    parameter int unsigned AW     = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [71:0]     kernel,
    output logic            busy,
    output logic            done,
    output logic            mem_rd_en,
    output logic [AW-1:0]   mem_addr,
    input  logic [BITW-1:0] mem_rd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITW-1:0] out_data,
    output logic [7:0]      out_x,
    output logic [7:0]      out_y,
    output logic            out_last
);

    localparam int unsigned XW    = 8;
    localparam int unsigned KW    = 8;
    localparam int unsigned NTAP  = 9;
    localparam int unsigned TAPW  = 4;
    localparam int unsigned PRODW = KW + BITW + 1;
    localparam logic [ACCW-1:0] PIX_MAX = ACCW'(2**BITW - 1);
    localparam logic [TAPW-1:0] LAST_TAP = TAPW'(NTAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [XW-1:0]          x_q, x_d;
    logic [XW-1:0]          y_q, y_d;
    logic [TAPW-1:0]        tap_q, tap_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [KW*NTAP-1:0]     kern_q, kern_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   mem_rd_en_q, mem_rd_en_d;
    logic [AW-1:0]          mem_addr_q, mem_addr_d;
    logic                   out_valid_q, out_valid_d;
    logic [BITW-1:0]        out_data_q, out_data_d;
    logic [XW-1:0]          out_x_q, out_x_d;
    logic [XW-1:0]          out_y_q, out_y_d;
    logic                   out_last_q, out_last_d;

    logic                   is_border;
    logic                   is_last;
    logic [TAPW-1:0]        mac_idx;
    logic signed [KW-1:0]   k_sel;
    logic signed [BITW:0]   pix_s;
    logic signed [PRODW-1:0] prod;
    logic signed [ACCW-1:0] prod_ext;
    logic signed [ACCW-1:0] acc_sum;
    logic [ACCW-1:0]        acc_abs;
    logic [BITW-1:0]        res_clamped;

    // Address of tap t (row-major within the 3x3 window) centred on (cx, cy).
    function automatic logic [AW-1:0] tap_addr(input logic [XW-1:0] cx,
                                               input logic [XW-1:0] cy,
                                               input logic [TAPW-1:0] t);
        int row;
        int col;
        row = int'(cy) + int'(t) / 3 - 1;
        col = int'(cx) + int'(t) % 3 - 1;
        return AW'(row * int'(WIDTH) + col);
    endfunction

    assign is_border = (x_q == '0) || (x_q == XW'(WIDTH - 1)) ||
                       (y_q == '0) || (y_q == XW'(HEIGHT - 1));
    assign is_last   = (x_q == XW'(WIDTH - 1)) && (y_q == XW'(HEIGHT - 1));

    // Read data lags its strobe by one cycle, so the tap being accumulated is one behind.
    assign mac_idx     = (state_q == S_DRAIN) ? LAST_TAP : TAPW'(tap_q - TAPW'(1));
    assign k_sel       = $signed(kern_q[{mac_idx, 3'b000} +: KW]);
    assign pix_s       = $signed({1'b0, mem_rd_data});
    assign prod        = PRODW'(k_sel) * PRODW'(pix_s);
    assign prod_ext    = ACCW'(prod);
    assign acc_sum     = acc_q + prod_ext;
    assign acc_abs     = acc_sum[ACCW-1] ? ACCW'(-acc_sum) : ACCW'(acc_sum);
    assign res_clamped = (acc_abs > PIX_MAX) ? BITW'(PIX_MAX) : acc_abs[BITW-1:0];

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        kern_d      = kern_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_last_d  = out_last_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    kern_d  = kernel;
                    x_d     = '0;
                    y_d     = '0;
                    busy_d  = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                acc_d = '0;
                if (is_border) begin
                    out_valid_d = 1'b1;
                    out_data_d  = '0;
                    out_x_d     = x_q;
                    out_y_d     = y_q;
                    out_last_d  = is_last;
                    state_d     = S_OUT;
                end else begin
                    tap_d       = '0;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = tap_addr(x_q, y_q, '0);
                    state_d     = S_READ;
                end
            end
            S_READ: begin
                if (tap_q != '0) begin
                    acc_d = acc_sum;
                end
                if (tap_q == LAST_TAP) begin
                    state_d = S_DRAIN;
                end else begin
                    tap_d       = TAPW'(tap_q + TAPW'(1));
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = tap_addr(x_q, y_q, TAPW'(tap_q + TAPW'(1)));
                end
            end
            S_DRAIN: begin
                acc_d       = acc_sum;
                out_valid_d = 1'b1;
                out_data_d  = res_clamped;
                out_x_d     = x_q;
                out_y_d     = y_q;
                out_last_d  = is_last;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        if (x_q == XW'(WIDTH - 1)) begin
                            x_d = '0;
                            y_d = XW'(y_q + XW'(1));
                        end else begin
                            x_d = XW'(x_q + XW'(1));
                        end
                        state_d = S_CHECK;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            tap_q       <= '0;
            acc_q       <= '0;
            kern_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            tap_q       <= tap_d;
            acc_q       <= acc_d;
            kern_q      <= kern_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_last_q  <= out_last_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv3x3_frame_sequencer.sv
// Scoreboard bench for conv3x3_frame_sequencer: a reference convolution model fills the
// expected-pixel queue at each start, and a negedge monitor pops it on every handshake.
module tb_conv3x3_frame_sequencer;

    localparam int unsigned W  = 16;
    localparam int unsigned H  = 16;
    localparam int unsigned AW = 8;
    localparam int FRAME_CYC   = 2473;
    localparam int MAX_CYC     = 6000;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] x;
        logic [7:0] y;
        logic       last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [71:0]   kernel = '0;
    logic          busy, done, mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [7:0]    out_data, out_x, out_y;
    logic          out_last;

    logic [7:0]  img [0:W*H-1];
    exp_t        sb [$];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          stall_en = 1'b0;
    int          stall_cnt = 0;
    logic [71:0] sobx;
    logic [71:0] zero_k;

    conv3x3_frame_sequencer #(
        .WIDTH(W), .HEIGHT(H), .BITW(8), .ACCW(20), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .kernel(kernel),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_x(out_x), .out_y(out_y), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= img[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [71:0] k, input int x, input int y);
        int acc;
        logic [7:0] kb;
        if (x == 0 || y == 0 || x == W - 1 || y == H - 1) return 8'd0;
        acc = 0;
        for (int i = 0; i < 9; i++) begin
            kb = k[8*i +: 8];
            acc += int'($signed(kb)) * int'(img[(y + i / 3 - 1) * W + (x + i % 3 - 1)]);
        end
        if (acc < 0) acc = -acc;
        return (acc > 255) ? 8'd255 : 8'(acc);
    endfunction

    task automatic fill(input int mode);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                case (mode)
                    0: img[y*W + x] = 8'h80;
                    1: img[y*W + x] = 8'(x);
                    2: img[y*W + x] = (x < 8) ? 8'd0 : 8'd255;
                    default: img[y*W + x] = (x < 8) ? 8'd255 : 8'd0;
                endcase
    endtask

    // Drives the handshake side: stalls once at (1,1) when asked, and scores each accepted pixel.
    always @(negedge clk) begin
        exp_t e;
        if (!stall_en) stall_cnt = 0;
        out_ready = 1'b1;
        if (stall_en && stall_cnt < 5 && out_valid && out_x == 8'd1 && out_y == 8'd1) begin
            out_ready = 1'b0;
            stall_cnt++;
            if (sb.size() > 0) check("stall_data", 32'(out_data), 32'(sb[0].d));
            check("stall_rd_en", 32'(mem_rd_en), 32'd0);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check($sformatf("px(%0d,%0d)", e.x, e.y),
                      32'({out_data, out_x, out_y, out_last}), 32'(e));
            end
        end
    end

    task automatic run_frame(input logic [71:0] k, input bit inject, input bit rst_mid,
                             input bit stall);
        exp_t e;
        int   cyc;
        bit   rst_hit;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                e.d    = model(k, x, y);
                e.x    = 8'(x);
                e.y    = 8'(y);
                e.last = (x == W - 1) && (y == H - 1);
                sb.push_back(e);
            end
        stall_en = stall;
        rst_hit  = 1'b0;
        @(negedge clk);
        kernel = k;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < MAX_CYC) begin
            if (inject && cyc == 300) begin
                kernel = zero_k;
                start  = 1'b1;
            end
            if (inject && cyc == 301) start = 1'b0;
            if (rst_mid && out_valid && out_x == 8'd5 && out_y == 8'd5) begin
                rst_hit = 1'b1;
                #2 rst_n = 1'b0;
                #1;
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_rd_en", 32'(mem_rd_en), 32'd0);
                check("rst_outs", 32'({done, out_data, out_x, out_y, out_last}), 32'd0);
                sb.delete();
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        stall_en = 1'b0;
        if (rst_mid) begin
            check("rst_hit", 32'(rst_hit), 32'd1);
            return;
        end
        check("done_cycle", 32'(cyc), 32'(stall ? FRAME_CYC + 5 : FRAME_CYC));
        check("busy_at_done", 32'(busy), 32'd0);
        check("valid_at_done", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("done_pulse_width", 32'(done), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int kv [9];
        kv = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
        for (int i = 0; i < 9; i++) sobx[8*i +: 8] = 8'(kv[i]);
        zero_k = '0;

        repeat (3) @(negedge clk);
        check("reset_ctrl", 32'({busy, done, out_valid, mem_rd_en, out_last}), 32'd0);
        check("reset_data", 32'({out_data, out_x, out_y}), 32'd0);
        check("reset_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        fill(1);
        run_frame(sobx, 1'b0, 1'b1, 1'b0);
        run_frame(sobx, 1'b0, 1'b0, 1'b0);

        fill(0);
        run_frame(sobx, 1'b0, 1'b0, 1'b0);

        fill(1);
        run_frame(sobx, 1'b0, 1'b0, 1'b0);

        fill(2);
        run_frame(sobx, 1'b0, 1'b0, 1'b0);
        fill(3);
        run_frame(sobx, 1'b0, 1'b0, 1'b0);

        fill(1);
        run_frame(sobx, 1'b0, 1'b0, 1'b1);

        run_frame(sobx, 1'b1, 1'b0, 1'b0);
        run_frame(zero_k, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
